s4_result_collector: RTL and testbench

//  Downstream stage of the s4 datapath. s4 has no stall and a fixed two-register latency, so this block provides the flow control.
//  - Tracks which issued operand triples (a,b,c) are in flight through s4.
//  - Captures each resulting {z,x} pair into a small FIFO and presents it on a valid/ready output.
//  - Applies credit-based backpressure (issue_ready) so that no s4 result is ever lost.

---
 rtl/s4_result_collector.sv | 87 ++++++++
 tb/tb_s4_result_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/s4_result_collector.sv
// Result collector for the s4 datapath: tracks in-flight issues, buffers {z,x}
// results in a small FIFO and throttles upstream with occupancy-based credits.
module s4_result_collector #(
  parameter int DATAWIDTH = 32,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [DATAWIDTH-1:0] z,
  input  logic [DATAWIDTH-1:0] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_z,
  output logic [DATAWIDTH-1:0] out_x,
  output logic [15:0]          result_count,
  output logic                 err_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0]   vpipe;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [OW-1:0]        occupancy;
  logic [DATAWIDTH-1:0] mem_z [DEPTH];
  logic [DATAWIDTH-1:0] mem_x [DEPTH];
  logic [CW-1:0]        credit_used;
  logic                 issue_fire;
  logic                 push;
  logic                 pop;

  // Credits count stored plus in-flight results, so the FIFO always has room
  // for everything s4 will deliver; no path from out_ready reaches issue_ready.
  always_comb begin
    credit_used = CW'(occupancy) + CW'($countones(vpipe));
    issue_ready = (credit_used < CW'(DEPTH));
    issue_fire  = issue_valid & issue_ready;
    out_valid   = (occupancy != '0);
    pop         = out_valid & out_ready;
    push        = vpipe[LATENCY-1] & ((occupancy != OW'(DEPTH)) | pop);
    out_z       = out_valid ? mem_z[rd_ptr] : '0;
    out_x       = out_valid ? mem_x[rd_ptr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      result_count <= '0;
      err_drop     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_z[i] <= '0;
        mem_x[i] <= '0;
      end
    end else begin
      vpipe[0] <= issue_fire;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      if (issue_valid && !issue_ready) begin
        err_drop <= 1'b1;
      end
      if (push) begin
        mem_z[wr_ptr] <= z;
        mem_x[wr_ptr] <= x;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        result_count <= result_count + 16'd1;
      end
      if (push && !pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (pop && !push) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s4_result_collector.sv
// Directed bench for s4_result_collector with a two-register s4 stand-in
// feeding z/x from the operands presented alongside each issue.
module tb_s4_result_collector;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [DW-1:0] z;
  logic [DW-1:0] x;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_z;
  logic [DW-1:0] out_x;
  logic [15:0]   result_count;
  logic          err_drop;

  logic [DW-1:0] in_z;
  logic [DW-1:0] in_x;
  logic [DW-1:0] s1_z;
  logic [DW-1:0] s1_x;
  logic [DW-1:0] exp_z;
  logic [DW-1:0] exp_x;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // s4 stand-in: two registers, no stall
  always @(posedge clk) begin
    s1_z <= in_z;
    s1_x <= in_x;
    z    <= s1_z;
    x    <= s1_x;
  end

  s4_result_collector #(.DATAWIDTH(DW), .LATENCY(2), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .z            (z),
    .x            (x),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_x        (out_x),
    .result_count (result_count),
    .err_drop     (err_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; in_z = '0; in_x = '0;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_z !== '0 || out_x !== '0) begin n_fail++; $display("FAIL reset_out_data: got z=%0h x=%0h want 0", out_z, out_x); end
    n_checks++; if (result_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", result_count); end
    n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL reset_err_drop: got %b want 0", err_drop); end
    rst = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
  endtask

  task automatic test_single();
    issue_valid = 1'b1; in_z = 32'd5; in_x = -32'sd3;
    step();
    issue_valid = 1'b0; in_z = '0; in_x = '0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    step();
    exp_x = -32'sd3;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_checks++; if (out_z !== 32'd5 || out_x !== exp_x) begin n_fail++; $display("FAIL single_data: got z=%0d x=%0d want z=5 x=-3", $signed(out_z), $signed(out_x)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (result_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", result_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    int accepted;
    accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; in_z = 32'(10 + i); in_x = -32'(10 + i);
      if (issue_ready === 1'b1) accepted++;
      step();
    end
    issue_valid = 1'b0;
    n_checks++; if (accepted != 4) begin n_fail++; $display("FAIL fill_accepted: got %0d want 4", accepted); end
    n_checks++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL fill_err_drop: got %b want 1", err_drop); end
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_low: got %b want 0", issue_ready); end
    step(); step(); step();
    exp_x = -32'sd10;
    n_checks++; if (out_valid !== 1'b1 || out_z !== 32'd10 || out_x !== exp_x) begin n_fail++; $display("FAIL fill_head: got v=%b z=%0d x=%0d want v=1 z=10 x=-10", out_valid, $signed(out_z), $signed(out_x)); end
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", issue_ready); end
  endtask

  task automatic test_credit_release();
    out_ready = 1'b1;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_no_comb_path: got %b want 0", issue_ready); end
    step();
    out_ready = 1'b0;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL credit_released: got %b want 1", issue_ready); end
    n_checks++; if (out_z !== 32'd11 || result_count !== 16'd2) begin n_fail++; $display("FAIL credit_head: got z=%0d cnt=%0d want z=11 cnt=2", $signed(out_z), result_count); end
    issue_valid = 1'b1; in_z = 32'd20; in_x = -32'sd20;
    step();
    issue_valid = 1'b0;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_consumed: got %b want 0", issue_ready); end
    step(); step();
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_full_again: got %b want 0", issue_ready); end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_z = 32'(11 + j);
      n_checks++; if (out_valid !== 1'b1 || out_z !== exp_z) begin n_fail++; $display("FAIL credit_drain_%0d: got v=%b z=%0d want v=1 z=%0d", j, out_valid, $signed(out_z), 11 + j); end
      step();
    end
    out_ready = 1'b0;
    exp_x = -32'sd20;
    n_checks++; if (out_z !== 32'd20 || out_x !== exp_x) begin n_fail++; $display("FAIL credit_late_entry: got z=%0d x=%0d want z=20 x=-20", $signed(out_z), $signed(out_x)); end
    n_checks++; if (result_count !== 16'd5 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL credit_after_drain: got cnt=%0d rdy=%b want cnt=5 rdy=1", result_count, issue_ready); end
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || out_z !== '0 || out_x !== '0) begin n_fail++; $display("FAIL midrun_outputs: got v=%b z=%0h x=%0h want 0", out_valid, out_z, out_x); end
    n_checks++; if (result_count !== 16'd0 || err_drop !== 1'b0) begin n_fail++; $display("FAIL midrun_state: got cnt=%0d err=%b want 0 0", result_count, err_drop); end
    rst = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_ready: got %b want 1", issue_ready); end
  endtask

  task automatic test_streaming();
    int received;
    int first_c;
    int last_c;
    received = 0; first_c = -1; last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 10) begin
        issue_valid = 1'b1; in_z = 32'(c + 1); in_x = -32'(c + 1);
      end else begin
        issue_valid = 1'b0;
      end
      step();
      if (out_valid === 1'b1) begin
        exp_z = 32'(received + 1);
        exp_x = -32'(received + 1);
        n_checks++; if (out_z !== exp_z || out_x !== exp_x) begin n_fail++; $display("FAIL stream_item_%0d: got z=%0d x=%0d want z=%0d x=%0d", received, $signed(out_z), $signed(out_x), $signed(exp_z), $signed(exp_x)); end
        if (first_c < 0) first_c = c;
        last_c = c;
        received++;
      end
    end
    n_checks++; if (received != 10) begin n_fail++; $display("FAIL stream_received: got %0d want 10", received); end
    n_checks++; if (first_c != 2 || last_c != 11) begin n_fail++; $display("FAIL stream_timing: got first=%0d last=%0d want 2 11", first_c, last_c); end
    n_checks++; if (result_count !== 16'd10 || err_drop !== 1'b0) begin n_fail++; $display("FAIL stream_totals: got cnt=%0d err=%b want 10 0", result_count, err_drop); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    issue_valid = 1'b1; in_z = 32'd77; in_x = 32'd88;
    step(); step();
    issue_valid = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midflight_valid: got %0d valid cycles want 0", seen); end
    n_checks++; if (result_count !== 16'd0) begin n_fail++; $display("FAIL midflight_count: got %0d want 0", result_count); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_credit_release();
    test_reset_midrun();
    test_streaming();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
